alu_seq_ctrl: RTL and testbench

Register-transfer sequencer for the phase-1 datapath ALU. On a `start` pulse it runs one three-operand ALU instruction, Rc ← Ra op Rb, by stepping through the bus control strobes:
- drive Ra and load Y;
- drive Rb with the opcode applied and load Z;
- write ZLo back to Rc.

Multi-cycle mul/div ops get a programmable wait, and their 64-bit result is written to the LO/HI pair. The block sits between the instruction-decode stub and the shared bus/register file/ALU, and is the only source of their control strobes during an operation.

---
 rtl/alu_seq_ctrl_if.sv | 39 +++
 rtl/alu_seq_ctrl.sv | 234 +++++++++++++++++++++++
 tb/tb_alu_seq_ctrl.sv | 189 ++++++++++++++++++
 3 files changed

// File: rtl/alu_seq_ctrl_if.sv
`default_nettype none
// ============================================================================
// Module      : alu_seq_ctrl_if
// Description : Request and strobe bundle between decode and the ALU sequencer.
// Revision    : 1.0 - initial release
// ============================================================================
interface alu_seq_ctrl_if;
    logic       start;
    logic [4:0] opcode_in;
    logic [3:0] ra_sel;
    logic [3:0] rb_sel;
    logic [3:0] rc_sel;
    logic       busy;
    logic       done;
    logic       illegal;
    logic [4:0] alu_op;
    logic [3:0] reg_sel;
    logic       rout;
    logic       rin;
    logic       yin;
    logic       zin;
    logic       zlo_out;
    logic       zhi_out;
    logic       lo_in;
    logic       hi_in;

    modport master (
        output start, opcode_in, ra_sel, rb_sel, rc_sel,
        input  busy, done, illegal, alu_op, reg_sel, rout, rin, yin, zin,
               zlo_out, zhi_out, lo_in, hi_in
    );

    modport slave (
        input  start, opcode_in, ra_sel, rb_sel, rc_sel,
        output busy, done, illegal, alu_op, reg_sel, rout, rin, yin, zin,
               zlo_out, zhi_out, lo_in, hi_in
    );
endinterface
`default_nettype wire

// File: rtl/alu_seq_ctrl.sv
`default_nettype none
// ============================================================================
// Module      : alu_seq_ctrl
// Description : Moore sequencer driving bus strobes for Rc <= Ra op Rb.
//               Define ALU_SEQ_MULDIV_EN to compile in mul/div sequencing.
// Revision    : 1.0 - initial release
// ============================================================================
module alu_seq_ctrl #(
    parameter int wordSize      = 32,
    parameter int MULDIV_CYCLES = 32
) (
    input  logic          clk,
    input  logic          clr,
    alu_seq_ctrl_if.slave bus
);

    if ((MULDIV_CYCLES < 1) || (wordSize < 1)) begin : g_param_check
        $error("alu_seq_ctrl: MULDIV_CYCLES and wordSize must be at least 1");
    end

    localparam logic [4:0] c_OP_MUL = 5'b00011;
    localparam logic [4:0] c_OP_DIV = 5'b00100;

    typedef enum logic [2:0] {
        S_IDLE  = 3'd0,
        S_TY    = 3'd1,
        S_EXEC  = 3'd2,
        S_WB_LO = 3'd3,
        S_DONE  = 3'd4
`ifdef ALU_SEQ_MULDIV_EN
        ,
        S_WAIT  = 3'd5,
        S_WB_HI = 3'd6
`endif
    } state_t;

    state_t     r_state;
    logic [4:0] r_op;
    logic [3:0] r_rb;
    logic [3:0] r_rc;
    logic       r_done;
    logic       r_illegal;
    logic [4:0] r_alu_op;
    logic [3:0] r_reg_sel;
    logic       r_rout;
    logic       r_rin;
    logic       r_yin;
    logic       r_zin;
    logic       r_zlo_out;

    logic w_is_muldiv_in;
    logic w_legal;

    assign w_is_muldiv_in = (bus.opcode_in == c_OP_MUL) || (bus.opcode_in == c_OP_DIV);

`ifdef ALU_SEQ_MULDIV_EN
    localparam int           c_CW       = $clog2(MULDIV_CYCLES + 1);
    localparam bit           c_MD_MULTI = (MULDIV_CYCLES > 1);
    // T_WAIT lasts MULDIV_CYCLES-1 cycles, counting the load value down to zero.
    localparam logic [c_CW-1:0] c_CNT_LOAD = c_CW'((MULDIV_CYCLES > 1) ? (MULDIV_CYCLES - 2) : 0);

    logic            r_muldiv;
    logic [c_CW-1:0] r_cnt;
    logic            r_zhi_out;
    logic            r_lo_in;
    logic            r_hi_in;

    assign w_legal = (bus.opcode_in != 5'd0) && !bus.opcode_in[4];
`else
    assign w_legal = (bus.opcode_in != 5'd0) && !bus.opcode_in[4] && !w_is_muldiv_in;
`endif

    // Outputs are registered for the state being entered, so they line up with r_state.
    always_ff @(posedge clk) begin
        if (clr) begin
            r_state   <= S_IDLE;
            r_op      <= '0;
            r_rb      <= '0;
            r_rc      <= '0;
            r_done    <= 1'b0;
            r_illegal <= 1'b0;
            r_alu_op  <= '0;
            r_reg_sel <= '0;
            r_rout    <= 1'b0;
            r_rin     <= 1'b0;
            r_yin     <= 1'b0;
            r_zin     <= 1'b0;
            r_zlo_out <= 1'b0;
`ifdef ALU_SEQ_MULDIV_EN
            r_muldiv  <= 1'b0;
            r_cnt     <= '0;
            r_zhi_out <= 1'b0;
            r_lo_in   <= 1'b0;
            r_hi_in   <= 1'b0;
`endif
        end else begin
            r_done    <= 1'b0;
            r_illegal <= 1'b0;
            r_alu_op  <= '0;
            r_reg_sel <= '0;
            r_rout    <= 1'b0;
            r_rin     <= 1'b0;
            r_yin     <= 1'b0;
            r_zin     <= 1'b0;
            r_zlo_out <= 1'b0;
`ifdef ALU_SEQ_MULDIV_EN
            r_zhi_out <= 1'b0;
            r_lo_in   <= 1'b0;
            r_hi_in   <= 1'b0;
`endif
            case (r_state)
                S_IDLE: begin
                    if (bus.start) begin
                        r_op <= bus.opcode_in;
                        r_rb <= bus.rb_sel;
                        r_rc <= bus.rc_sel;
`ifdef ALU_SEQ_MULDIV_EN
                        r_muldiv <= w_is_muldiv_in;
`endif
                        if (w_legal) begin
                            r_state   <= S_TY;
                            r_rout    <= 1'b1;
                            r_reg_sel <= bus.ra_sel;
                            r_yin     <= 1'b1;
                        end else begin
                            r_state   <= S_DONE;
                            r_done    <= 1'b1;
                            r_illegal <= 1'b1;
                        end
                    end
                end
                S_TY: begin
                    r_state   <= S_EXEC;
                    r_rout    <= 1'b1;
                    r_reg_sel <= r_rb;
                    r_alu_op  <= r_op;
`ifdef ALU_SEQ_MULDIV_EN
                    r_zin     <= !(r_muldiv && c_MD_MULTI);
`else
                    r_zin     <= 1'b1;
`endif
                end
                S_EXEC: begin
`ifdef ALU_SEQ_MULDIV_EN
                    if (r_muldiv && c_MD_MULTI) begin
                        r_state   <= S_WAIT;
                        r_cnt     <= c_CNT_LOAD;
                        r_rout    <= 1'b1;
                        r_reg_sel <= r_rb;
                        r_alu_op  <= r_op;
                        r_zin     <= (c_CNT_LOAD == '0);
                    end else begin
                        r_state   <= S_WB_LO;
                        r_zlo_out <= 1'b1;
                        if (r_muldiv) begin
                            r_lo_in <= 1'b1;
                        end else begin
                            r_rin     <= 1'b1;
                            r_reg_sel <= r_rc;
                        end
                    end
`else
                    r_state   <= S_WB_LO;
                    r_zlo_out <= 1'b1;
                    r_rin     <= 1'b1;
                    r_reg_sel <= r_rc;
`endif
                end
`ifdef ALU_SEQ_MULDIV_EN
                S_WAIT: begin
                    if (r_cnt == '0) begin
                        r_state   <= S_WB_LO;
                        r_zlo_out <= 1'b1;
                        r_lo_in   <= 1'b1;
                    end else begin
                        r_cnt     <= r_cnt - c_CW'(1);
                        r_rout    <= 1'b1;
                        r_reg_sel <= r_rb;
                        r_alu_op  <= r_op;
                        r_zin     <= (r_cnt == c_CW'(1));
                    end
                end
                S_WB_LO: begin
                    if (r_muldiv) begin
                        r_state   <= S_WB_HI;
                        r_zhi_out <= 1'b1;
                        r_hi_in   <= 1'b1;
                    end else begin
                        r_state <= S_DONE;
                        r_done  <= 1'b1;
                    end
                end
                S_WB_HI: begin
                    r_state <= S_DONE;
                    r_done  <= 1'b1;
                end
`else
                S_WB_LO: begin
                    r_state <= S_DONE;
                    r_done  <= 1'b1;
                end
`endif
                S_DONE: begin
                    r_state <= S_IDLE;
                end
                default: begin
                    r_state <= S_IDLE;
                end
            endcase
        end
    end

    assign bus.busy    = (r_state != S_IDLE);
    assign bus.done    = r_done;
    assign bus.illegal = r_illegal;
    assign bus.alu_op  = r_alu_op;
    assign bus.reg_sel = r_reg_sel;
    assign bus.rout    = r_rout;
    assign bus.rin     = r_rin;
    assign bus.yin     = r_yin;
    assign bus.zin     = r_zin;
    assign bus.zlo_out = r_zlo_out;
`ifdef ALU_SEQ_MULDIV_EN
    assign bus.zhi_out = r_zhi_out;
    assign bus.lo_in   = r_lo_in;
    assign bus.hi_in   = r_hi_in;
`else
    assign bus.zhi_out = 1'b0;
    assign bus.lo_in   = 1'b0;
    assign bus.hi_in   = 1'b0;
`endif

endmodule
`default_nettype wire

// File: tb/tb_alu_seq_ctrl.sv
`default_nettype none
// ============================================================================
// Module      : tb_alu_seq_ctrl
// Description : Self-checking bench for alu_seq_ctrl against a per-cycle timeline model.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_alu_seq_ctrl;

    localparam int c_N = 32;

    logic clk;
    logic clr;
    int   n_cmp;
    int   n_err;

    alu_seq_ctrl_if bus ();

    alu_seq_ctrl #(
        .wordSize      (32),
        .MULDIV_CYCLES (c_N)
    ) dut (
        .clk (clk),
        .clr (clr),
        .bus (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial begin
        #500000;
        $display("FAIL watchdog: observed no end of run, required finish before time limit");
        $fatal(1, "watchdog expired");
    end

    function automatic bit md_enabled();
`ifdef ALU_SEQ_MULDIV_EN
        return 1'b1;
`else
        return 1'b0;
`endif
    endfunction

    function automatic bit is_md(input logic [4:0] op);
        return md_enabled() && (op == 5'd3 || op == 5'd4);
    endfunction

    function automatic bit is_legal(input logic [4:0] op);
        if (op == 5'd0 || op > 5'd15) return 1'b0;
        if (!md_enabled() && (op == 5'd3 || op == 5'd4)) return 1'b0;
        return 1'b1;
    endfunction

    // Cycle at which done is expected, counting the accepting edge as 0.
    function automatic int latency(input logic [4:0] op);
        if (!is_legal(op)) return 1;
        return is_md(op) ? c_N + 4 : 4;
    endfunction

    // Expected outputs in cycle k: {busy,done,illegal,alu_op,reg_sel,rout,rin,yin,zin,zlo,zhi,lo,hi}
    function automatic logic [19:0] model(input int k, input logic [4:0] op,
                                          input logic [3:0] ra, input logic [3:0] rb,
                                          input logic [3:0] rc);
        logic busy, done, ill, rout, rin, yin, zin, zlo, zhi, loi, hii;
        logic [4:0] aop;
        logic [3:0] sel;
        int last_exec;
        {busy, done, ill, rout, rin, yin, zin, zlo, zhi, loi, hii} = '0;
        aop = '0;
        sel = '0;
        if (!is_legal(op)) begin
            if (k == 1) {busy, done, ill} = 3'b111;
        end else begin
            last_exec = is_md(op) ? c_N + 1 : 2;
            if (k == 1) begin
                busy = 1; rout = 1; yin = 1; sel = ra;
            end else if (k >= 2 && k <= last_exec) begin
                busy = 1; rout = 1; sel = rb; aop = op; zin = (k == last_exec);
            end else if (k == last_exec + 1) begin
                busy = 1; zlo = 1;
                if (is_md(op)) loi = 1;
                else begin rin = 1; sel = rc; end
            end else if (is_md(op) && k == last_exec + 2) begin
                busy = 1; zhi = 1; hii = 1;
            end else if (k == latency(op)) begin
                busy = 1; done = 1;
            end
        end
        return {busy, done, ill, aop, sel, rout, rin, yin, zin, zlo, zhi, loi, hii};
    endfunction

    task automatic check(input int k, input logic [19:0] exp, input string tag);
        logic [19:0] obs;
        obs = {bus.busy, bus.done, bus.illegal, bus.alu_op, bus.reg_sel, bus.rout, bus.rin,
               bus.yin, bus.zin, bus.zlo_out, bus.zhi_out, bus.lo_in, bus.hi_in};
        n_cmp++;
        assert (obs === exp) else begin
            n_err++;
            $error("FAIL %s cycle %0d: observed %h expected %h", tag, k, obs, exp);
        end
        n_cmp++;
        assert ($countones({bus.rout, bus.zlo_out, bus.zhi_out}) <= 1) else begin
            n_err++;
            $error("FAIL %s_excl cycle %0d: observed drivers %b expected at most one",
                   tag, k, {bus.rout, bus.zlo_out, bus.zhi_out});
        end
    endtask

    // Called from an IDLE cycle after its negedge; start is accepted at the next edge.
    task automatic run_op(input logic [4:0] op, input logic [3:0] ra, input logic [3:0] rb,
                          input logic [3:0] rc, input logic [63:0] pulses,
                          input int abort_k, input string tag);
        int lat;
        int last;
        lat  = latency(op);
        last = (abort_k > 0) ? abort_k + 3 : lat + 1;
        bus.start     = 1'b1;
        bus.opcode_in = op;
        bus.ra_sel    = ra;
        bus.rb_sel    = rb;
        bus.rc_sel    = rc;
        @(posedge clk);
        for (int k = 1; k <= last; k++) begin
            @(negedge clk);
            bus.start     = 1'b0;
            clr           = 1'b0;
            bus.opcode_in = 5'($urandom);
            bus.ra_sel    = 4'($urandom);
            bus.rb_sel    = 4'($urandom);
            bus.rc_sel    = 4'($urandom);
            check(k, (abort_k > 0 && k > abort_k) ? 20'd0 : model(k, op, ra, rb, rc), tag);
            if (k == abort_k) clr = 1'b1;
            if (k <= lat && pulses[k]) begin
                bus.start     = 1'b1;
                bus.opcode_in = 5'b01010;
            end
        end
    endtask

    initial begin
        logic [4:0] op;
        n_cmp         = 0;
        n_err         = 0;
        clr           = 1'b1;
        bus.start     = 1'b0;
        bus.opcode_in = '0;
        bus.ra_sel    = '0;
        bus.rb_sel    = '0;
        bus.rc_sel    = '0;
        repeat (2) @(posedge clk);
        @(negedge clk);
        check(0, 20'd0, "reset");

        // clr wins over a simultaneous start
        bus.start     = 1'b1;
        bus.opcode_in = 5'd1;
        @(posedge clk);
        @(negedge clk);
        check(0, 20'd0, "clr_prio");
        bus.start = 1'b0;
        clr       = 1'b0;
        @(negedge clk);
        check(0, 20'd0, "idle");

        run_op(5'd1, 4'd2, 4'd3, 4'd4, 64'd0, 0, "add");
        run_op(5'd4, 4'd5, 4'd6, 4'd7, 64'd0, 0, "div");
        run_op(5'd0, 4'd1, 4'd1, 4'd1, 64'd0, 0, "ill0");
        run_op(5'b10101, 4'd9, 4'd8, 4'd7, 64'd0, 0, "ill21");
        run_op(5'd1, 4'd1, 4'd2, 4'd3, 64'h14, 0, "busy_rej");
        run_op(5'd2, 4'd6, 4'd7, 4'd8, 64'd0, 0, "b2b");
        run_op(5'd3, 4'd3, 4'd4, 4'd5, 64'd0, 10, "abort");
        run_op(5'd1, 4'd10, 4'd11, 4'd12, 64'd0, 0, "post_abort");
        run_op(5'd3, 4'd1, 4'd2, 4'd3, 64'd0, 0, "mul");
        run_op(5'd12, 4'd14, 4'd0, 4'd15, 64'd0, 0, "unary");
        run_op(5'd15, 4'd15, 4'd15, 4'd0, 64'd0, 0, "op15");
        run_op(5'd16, 4'd2, 4'd2, 4'd2, 64'd0, 0, "op16");

        for (int i = 0; i < 30; i++) begin
            op = (i % 3 == 0) ? 5'($urandom_range(3, 4)) : 5'($urandom);
            run_op(op, 4'($urandom), 4'($urandom), 4'($urandom),
                   {$urandom, $urandom} & ~64'd1, 0, "rand");
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
`default_nettype wire
